// File: rtl/wb_pkg.sv
// Shared encodings for the writeback select unit: write-data select codes,
// load-type (funct3) codes, FSM states and the default datapath widths.
package wb_pkg;

    localparam int WB_XLEN       = 32;
    localparam int WB_REG_ADDR_W = 5;

    localparam logic [1:0] WDSEL_ALU = 2'b00;
    localparam logic [1:0] WDSEL_MEM = 2'b01;
    localparam logic [1:0] WDSEL_PC4 = 2'b10;

    localparam logic [2:0] DM_LB  = 3'b000;
    localparam logic [2:0] DM_LH  = 3'b001;
    localparam logic [2:0] DM_LW  = 3'b010;
    localparam logic [2:0] DM_LBU = 3'b100;
    localparam logic [2:0] DM_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        COMMIT   = 2'd2
    } wb_state_e;

endpackage

// File: rtl/load_aligner.sv
// Picks the addressed byte/half out of a word-aligned read word and extends it.
// Purely combinational; unknown load types pass the whole word through.
module load_aligner
    import wb_pkg::*;
#(
    parameter int XLEN = WB_XLEN
) (
    input  logic [XLEN-1:0] mem_rdata,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      dm_type,
    output logic [XLEN-1:0] load_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = mem_rdata[{addr_lo, 3'b000} +: 8];
    assign half_sel = mem_rdata[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        load_word = mem_rdata;
        case (dm_type)
            DM_LB:   load_word = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            DM_LH:   load_word = {{(XLEN-16){half_sel[15]}}, half_sel};
            DM_LBU:  load_word = {{(XLEN-8){1'b0}}, byte_sel};
            DM_LHU:  load_word = {{(XLEN-16){1'b0}}, half_sel};
            default: load_word = mem_rdata;
        endcase
    end

endmodule

// File: rtl/wb_select_unit.sv
// Writeback stage: accepts one retiring instruction, selects ALU / load / PC+4
// data, waits for the memory response on loads and emits a one-cycle write strobe.
module wb_select_unit
    import wb_pkg::*;
#(
    parameter int XLEN       = WB_XLEN,
    parameter int REG_ADDR_W = WB_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [1:0]            wdsel,
    input  logic                  regwrite,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic [XLEN-1:0]       alu_result,
    input  logic [XLEN-1:0]       pc,
    input  logic [2:0]            dm_type,
    input  logic                  mem_rvalid,
    input  logic [XLEN-1:0]       mem_rdata,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,
    output logic                  busy
);

    wb_state_e             state_q, state_d;
    logic                  regwrite_q, regwrite_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [2:0]            dm_type_q, dm_type_d;
    logic [1:0]            addr_lo_q, addr_lo_d;
    logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]       rf_wdata_q, rf_wdata_d;
    logic [XLEN-1:0]       load_word;
    logic [XLEN-1:0]       direct_data;
    logic                  accept;

    load_aligner #(
        .XLEN (XLEN)
    ) u_load_aligner (
        .mem_rdata (mem_rdata),
        .addr_lo   (addr_lo_q),
        .dm_type   (dm_type_q),
        .load_word (load_word)
    );

    // Select code 11 falls back to the ALU result, same as 00.
    assign direct_data = (wdsel == WDSEL_PC4) ? (pc + XLEN'(4)) : alu_result;

    assign issue_ready = rstn && (state_q == IDLE);
    assign accept      = issue_valid && (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign rf_we       = (state_q == COMMIT) && regwrite_q && (rd_q != '0);
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = rf_wdata_q;

    always_comb begin
        state_d    = state_q;
        regwrite_d = regwrite_q;
        rd_d       = rd_q;
        dm_type_d  = dm_type_q;
        addr_lo_d  = addr_lo_q;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;

        if (accept) begin
            regwrite_d = regwrite;
            rd_d       = rd;
            dm_type_d  = dm_type;
            addr_lo_d  = alu_result[1:0];
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (wdsel == WDSEL_MEM) begin
                        state_d = WAIT_MEM;
                    end else begin
                        // Non-loads publish their data on the accept edge so it
                        // is stable for the whole COMMIT cycle.
                        state_d    = COMMIT;
                        rf_waddr_d = rd;
                        rf_wdata_d = direct_data;
                    end
                end
            end
            WAIT_MEM: begin
                if (mem_rvalid) begin
                    state_d    = COMMIT;
                    rf_waddr_d = rd_q;
                    rf_wdata_d = load_word;
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            dm_type_q  <= DM_LW;
            addr_lo_q  <= 2'b00;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            dm_type_q  <= dm_type_d;
            addr_lo_q  <= addr_lo_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

endmodule

// File: tb/tb_wb_select_unit.sv
// Directed bench for wb_select_unit: reset, ALU/PC+4/load writeback, rd=0,
// spurious responses, back-to-back issue and reset during a pending load.
module tb_wb_select_unit;

    logic        clk;
    logic        rstn;
    logic        issue_valid;
    logic        issue_ready;
    logic [1:0]  wdsel;
    logic        regwrite;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] pc;
    logic [2:0]  dm_type;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        busy;

    int errors = 0;
    int checks = 0;

    wb_select_unit #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .wdsel       (wdsel),
        .regwrite    (regwrite),
        .rd          (rd),
        .alu_result  (alu_result),
        .pc          (pc),
        .dm_type     (dm_type),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offers one instruction; returns #1 after the accept edge.
    task automatic issue(input logic [1:0] ws, input logic rw, input logic [4:0] r,
                         input logic [31:0] alu, input logic [31:0] p, input logic [2:0] dt);
        wdsel = ws; regwrite = rw; rd = r; alu_result = alu; pc = p; dm_type = dt;
        issue_valid = 1'b1;
        @(posedge clk); #1;
        issue_valid = 1'b0;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", rf_we); end
        checks++; if (rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr got %h want 00", rf_waddr); end
        checks++; if (rf_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h want 00000000", rf_wdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        rstn = 1'b1;
        @(posedge clk); #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", issue_ready); end
    endtask

    task automatic test_alu_wb;
        issue(2'b00, 1'b1, 5'd5, 32'h0000_1234, 32'h0000_0100, 3'b010);
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL alu_we got %b want 1", rf_we); end
        checks++; if (rf_waddr !== 5'd5) begin errors++; $display("FAIL alu_waddr got %h want 05", rf_waddr); end
        checks++; if (rf_wdata !== 32'h0000_1234) begin errors++; $display("FAIL alu_wdata got %h want 00001234", rf_wdata); end
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL alu_ready_commit got %b want 0", issue_ready); end
        @(posedge clk); #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL alu_we_after got %b want 0", rf_we); end
        checks++; if (rf_wdata !== 32'h0000_1234) begin errors++; $display("FAIL alu_wdata_hold got %h want 00001234", rf_wdata); end
        // Select code 11 behaves like ALU.
        issue(2'b11, 1'b1, 5'd6, 32'h0BAD_F00D, 32'h0000_0200, 3'b010);
        checks++; if (rf_wdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL sel11_wdata got %h want 0badf00d", rf_wdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_pc4_wb;
        issue(2'b10, 1'b1, 5'd1, 32'hDEAD_0000, 32'h0000_0FFC, 3'b010);
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL pc4_we got %b want 1", rf_we); end
        checks++; if (rf_wdata !== 32'h0000_1000) begin errors++; $display("FAIL pc4_wdata got %h want 00001000", rf_wdata); end
        @(posedge clk); #1;
        issue(2'b10, 1'b1, 5'd1, 32'hDEAD_0000, 32'hFFFF_FFFC, 3'b010);
        checks++; if (rf_wdata !== 32'h0000_0000) begin errors++; $display("FAIL pc4_wrap got %h want 00000000", rf_wdata); end
        @(posedge clk); #1;
    endtask

    // One load with the response three cycles after accept.
    task automatic test_load_case(input logic [2:0] dt, input logic [1:0] a, input logic [31:0] exp);
        mem_rdata = 32'h80FF_7F01;
        issue(2'b01, 1'b1, 5'd7, 32'h0000_1000 | {30'd0, a}, 32'h0, dt);
        checks++; if (issue_ready !== 1'b0 || busy !== 1'b1 || rf_we !== 1'b0) begin
            errors++; $display("FAIL load_wait dt=%0d ready=%b busy=%b we=%b want 0/1/0", dt, issue_ready, busy, rf_we);
        end
        repeat (2) @(posedge clk);
        #1;
        mem_rvalid = 1'b1;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7) begin
            errors++; $display("FAIL load_we dt=%0d we=%b waddr=%h want 1/07", dt, rf_we, rf_waddr);
        end
        checks++; if (rf_wdata !== exp) begin
            errors++; $display("FAIL load_data dt=%0d a=%0d got %h want %h", dt, a, rf_wdata, exp);
        end
        @(posedge clk); #1;
        checks++; if (rf_we !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL load_done dt=%0d we=%b busy=%b want 0/0", dt, rf_we, busy);
        end
    endtask

    task automatic test_loads;
        test_load_case(3'b000, 2'd3, 32'hFFFF_FF80);
        test_load_case(3'b100, 2'd3, 32'h0000_0080);
        test_load_case(3'b001, 2'd2, 32'hFFFF_80FF);
        test_load_case(3'b101, 2'd0, 32'h0000_7F01);
        test_load_case(3'b010, 2'd3, 32'h80FF_7F01);
        test_load_case(3'b000, 2'd1, 32'h0000_007F);
        test_load_case(3'b111, 2'd1, 32'h80FF_7F01);
    endtask

    task automatic test_rd_zero;
        issue(2'b00, 1'b1, 5'd0, 32'h0000_7777, 32'h0, 3'b010);
        checks++; if (rf_we !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL rd0_commit we=%b busy=%b want 0/1", rf_we, busy);
        end
        @(posedge clk); #1;
        checks++; if (rf_we !== 1'b0 || busy !== 1'b0 || issue_ready !== 1'b1) begin
            errors++; $display("FAIL rd0_done we=%b busy=%b ready=%b want 0/0/1", rf_we, busy, issue_ready);
        end
    endtask

    task automatic test_spurious_rvalid;
        issue(2'b00, 1'b1, 5'd12, 32'h0000_00AA, 32'h0, 3'b010);
        @(posedge clk); #1;
        mem_rdata  = 32'h1111_2222;
        mem_rvalid = 1'b1;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        checks++; if (rf_we !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL spurious_idle we=%b busy=%b want 0/0", rf_we, busy);
        end
        checks++; if (rf_wdata !== 32'h0000_00AA || rf_waddr !== 5'd12) begin
            errors++; $display("FAIL spurious_hold wdata=%h waddr=%h want 000000aa/0c", rf_wdata, rf_waddr);
        end
    endtask

    task automatic test_rvalid_on_accept;
        mem_rdata  = 32'hCAFE_BABE;
        mem_rvalid = 1'b1;
        issue(2'b01, 1'b1, 5'd8, 32'h0000_2000, 32'h0, 3'b010);
        mem_rvalid = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b1 || rf_we !== 1'b0) begin
            errors++; $display("FAIL accept_rvalid busy=%b we=%b want 1/0", busy, rf_we);
        end
        mem_rdata  = 32'h0123_4567;
        mem_rvalid = 1'b1;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        checks++; if (rf_we !== 1'b1 || rf_wdata !== 32'h0123_4567) begin
            errors++; $display("FAIL accept_rvalid_late we=%b wdata=%h want 1/01234567", rf_we, rf_wdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        wdsel = 2'b00; regwrite = 1'b1; rd = 5'd20; alu_result = 32'h0000_0014; pc = 32'h0; dm_type = 3'b010;
        issue_valid = 1'b1;
        @(posedge clk); #1;
        rd = 5'd21; alu_result = 32'h0000_0015;
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd20) begin
            errors++; $display("FAIL b2b_first we=%b waddr=%h want 1/14", rf_we, rf_waddr);
        end
        @(posedge clk); #1;
        checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd20 || issue_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_gap we=%b waddr=%h ready=%b want 0/14/1", rf_we, rf_waddr, issue_ready);
        end
        @(posedge clk); #1;
        issue_valid = 1'b0;
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd21 || rf_wdata !== 32'h0000_0015) begin
            errors++; $display("FAIL b2b_second we=%b waddr=%h wdata=%h want 1/15/00000015", rf_we, rf_waddr, rf_wdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midrun;
        issue(2'b00, 1'b1, 5'd3, 32'h0000_ABCD, 32'h0, 3'b010);
        rstn = 1'b0;
        #1;
        checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'h0) begin
            errors++; $display("FAIL midrun_outputs we=%b waddr=%h wdata=%h want 0/00/00000000", rf_we, rf_waddr, rf_wdata);
        end
        checks++; if (busy !== 1'b0 || issue_ready !== 1'b0) begin
            errors++; $display("FAIL midrun_state busy=%b ready=%b want 0/0", busy, issue_ready);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        checks++; if (issue_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL midrun_release ready=%b busy=%b want 1/0", issue_ready, busy);
        end
    endtask

    task automatic test_reset_wait_mem;
        issue(2'b01, 1'b1, 5'd9, 32'h0000_3000, 32'h0, 3'b010);
        @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL waitrst_busy got %b want 0", busy); end
        @(posedge clk); #1;
        mem_rdata  = 32'h5A5A_5A5A;
        mem_rvalid = 1'b1;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        checks++; if (rf_we !== 1'b0 || busy !== 1'b0 || rf_waddr !== 5'd0) begin
            errors++; $display("FAIL waitrst_nowrite we=%b busy=%b waddr=%h want 0/0/00", rf_we, busy, rf_waddr);
        end
        issue(2'b00, 1'b1, 5'd10, 32'h0000_0055, 32'h0, 3'b010);
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd10 || rf_wdata !== 32'h0000_0055) begin
            errors++; $display("FAIL waitrst_new we=%b waddr=%h wdata=%h want 1/0a/00000055", rf_we, rf_waddr, rf_wdata);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rstn = 1'b0; issue_valid = 1'b0; wdsel = 2'b00; regwrite = 1'b0; rd = 5'd0;
        alu_result = 32'h0; pc = 32'h0; dm_type = 3'b010; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        #1;
        test_reset;
        test_alu_wb;
        test_pc4_wb;
        test_loads;
        test_rd_zero;
        test_spurious_rvalid;
        test_rvalid_on_accept;
        test_back_to_back;
        test_reset_midrun;
        test_reset_wait_mem;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
